ibex_instr_wb_bridge: RTL and testbench
=======================================

// Module: ibex_instr_wb_bridge
// PURPOSE
//  Converts the Ibex instruction-fetch port (req/gnt/rvalid/err) into a Wishbone B4 pipelined read master.
//  Sits between ibex_core instr_* port and the instruction-side WB interconnect / boot ROM.
//  Tracks outstanding fetches, holds CYC until all are answered, drains cleanly after a bus error.
// PARAMETERS
//  MaxOutstanding  2   max WB reads in flight (>=1); Ibex prefetch buffer issues at most 2
//  RegResp         0   1: register rvalid/rdata/err (+1 cycle latency); 0: combinational pass-through
// PORTS
//  clk           in   1   clock; all logic on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  instr_req     in   1   fetch request from core
//  instr_gnt     out  1   request accepted this cycle
//  instr_addr    in   32  fetch address, word aligned
//  instr_rvalid  out  1   response valid, one pulse per granted request
//  instr_rdata   out  32  fetched word
//  instr_err     out  1   response is a bus error (qualified by instr_rvalid)
//  wb_cyc        out  1   WB cycle
//  wb_stb        out  1   WB strobe
//  wb_we         out  1   constant 0
//  wb_sel        out  4   constant 4'hF
//  wb_adr        out  32  = instr_addr
//  wb_dat_i      in   32  WB read data
//  wb_ack        in   1   WB acknowledge
//  wb_err        in   1   WB error termination
//  wb_stall      in   1   WB pipeline stall
//  proto_err     out  1   sticky: ack/err received with nothing outstanding
// BEHAVIOUR
//  Reset: cnt=0, state=IDLE, wb_cyc=wb_stb=0, instr_gnt=0, instr_rvalid=0, instr_err=0, instr_rdata=0, proto_err=0.
//  Reset is honoured mid-transaction; in-flight responses are discarded and never reach the core.
//  cnt: outstanding counter, width $clog2(MaxOutstanding+1).
//  room = (cnt < MaxOutstanding) | rsp (a response frees one slot in the same cycle).
//  rsp  = (wb_ack | wb_err) & (cnt != 0).
//  issue = instr_req & room & (state != DRAIN); wb_stb = issue; instr_gnt = issue & ~wb_stall.
//  cnt_next = cnt + (instr_gnt) - (rsp); simultaneous grant+response leaves cnt unchanged; no wrap.
//  wb_cyc = wb_stb | (cnt != 0), except wb_cyc=0 in state GAP.
//  Response: instr_rvalid = rsp, instr_err = wb_err & rsp, instr_rdata = wb_dat_i.
//  RegResp=1: the same three signals registered, 1-cycle later; rdata holds its last value.
//  wb_ack and wb_err both high: treated as error (instr_err=1), single decrement.
//  Stray (wb_ack|wb_err) with cnt==0: ignored, proto_err <= 1 until reset.
//  FSM (ibex_wb_pkg::bridge_state_e):
//   IDLE   : cnt==0, no stb. -> ACTIVE on issue.
//   ACTIVE : -> DRAIN on rsp & wb_err; -> IDLE when cnt_next==0 and no issue.
//   DRAIN  : no new stb/gnt; remaining responses forwarded as normal.
//            -> GAP when cnt_next==0.
//   GAP    : one cycle with wb_cyc=0 (WB cycle terminated after error); -> IDLE.
//  Latency: RegResp=0 -> rvalid in the ack cycle; RegResp=1 -> ack cycle +1.
//  Zero-wait-state slave, no stall: one fetch per cycle sustained.
//  Stall held: gnt=0, stb and adr stay asserted (core keeps req/addr stable).
// STRUCTURE
//  ibex_wb_pkg: bridge_state_e {IDLE,ACTIVE,DRAIN,GAP}, WB_ADR_W=32, WB_DAT_W=32, WB_SEL_ALL=4'hF.
//  Single module, no sub-module; counter, FSM and optional response register are inline.
// TESTING
//  1 Reset: rst_n=0 with wb_ack=1 -> all outputs 0, proto_err=0; release -> IDLE.
//  2 Back-to-back, zero-wait slave: 8 reqs 0x80..0x9C -> gnt every cycle, 8 rvalid in order with
//    matching data, cnt<=2, wb_cyc drops the cycle after the last ack.
//  3 Backpressure: wb_stall=1 for 3 cycles with req=1, adr=0x100 -> gnt=0 for 3 cycles, stb/adr held,
//    gnt=1 in the 4th cycle.
//  4 Limit: slave delays acks 5 cycles, MaxOutstanding=2 -> third req not granted until the first ack;
//    grant+ack in the same cycle keeps cnt=2.
//  5 Error: wb_err on 1st of 2 in flight -> instr_err=1 with rvalid, no new gnt, 2nd response forwarded,
//    then one cycle wb_cyc=0, then IDLE.
//  6 Stray ack with cnt=0 -> instr_rvalid=0, proto_err=1 and sticky; repeat tests 2 and 5 with RegResp=1
//    (+1 cycle).

Source files
------------

// File: rtl/ibex_wb_pkg.sv
// Shared types and bus constants for the Ibex instruction-side Wishbone bridge.
package ibex_wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        GAP
    } bridge_state_e;

endpackage

// File: rtl/ibex_instr_wb_bridge.sv
// Ibex instruction-fetch port to Wishbone B4 pipelined read master.
// Counts outstanding reads, holds CYC until all are answered, drains and drops CYC after an error.
module ibex_instr_wb_bridge
    import ibex_wb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RegResp        = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_req,
    output logic                instr_gnt,
    input  logic [WB_ADR_W-1:0] instr_addr,
    output logic                instr_rvalid,
    output logic [WB_DAT_W-1:0] instr_rdata,
    output logic                instr_err,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic                wb_we,
    output logic [WB_SEL_W-1:0] wb_sel,
    output logic [WB_ADR_W-1:0] wb_adr,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    input  logic                wb_ack,
    input  logic                wb_err,
    input  logic                wb_stall,
    output logic                proto_err
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    bridge_state_e   state_q, state_d;
    logic [CntW-1:0] cnt, cnt_next;
    logic            rsp, rsp_err, stray, room, can_issue, issue;

    // A response frees its slot in the same cycle, so a new read may be issued alongside it.
    assign rsp       = (wb_ack | wb_err) & (cnt != '0);
    assign stray     = (wb_ack | wb_err) & (cnt == '0);
    assign rsp_err   = wb_err & rsp;
    assign room      = (cnt < CntMax) | rsp;
    // No strobe while draining or while the terminated cycle has CYC low.
    assign can_issue = (state_q == IDLE) | (state_q == ACTIVE);
    assign issue     = instr_req & room & can_issue;

    assign wb_stb    = issue;
    assign instr_gnt = issue & ~wb_stall;
    assign wb_cyc    = (state_q != GAP) & (issue | (cnt != '0));
    assign wb_we     = 1'b0;
    assign wb_sel    = WB_SEL_ALL;
    assign wb_adr    = instr_addr;

    assign cnt_next  = cnt + CntW'(instr_gnt) - CntW'(rsp);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (rsp_err)                              state_d = DRAIN;
                else if ((cnt_next == '0) && !issue)      state_d = IDLE;
            end
            DRAIN: begin
                if (cnt_next == '0) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt       <= cnt_next;
            proto_err <= proto_err | stray;
        end
    end

    // Response path: registered (+1 cycle, rdata holds) or straight through.
    if (RegResp) begin : g_reg_rsp
        logic                rvalid_q, err_q;
        logic [WB_DAT_W-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rsp;
                err_q    <= rsp_err;
                if (rsp) rdata_q <= wb_dat_i;
            end
        end

        assign instr_rvalid = rvalid_q;
        assign instr_err    = err_q;
        assign instr_rdata  = rdata_q;
    end else begin : g_comb_rsp
        assign instr_rvalid = rsp;
        assign instr_err    = rsp_err;
        assign instr_rdata  = wb_dat_i;
    end

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// Bench for ibex_instr_wb_bridge: two instances (pass-through and registered response) share one
// randomised core/slave environment and are checked every cycle against a transaction-level model.
module tb_ibex_instr_wb_bridge;

    localparam int unsigned MaxOut = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0, err = 1'b0, stall = 1'b0;
    logic [31:0] dat = '0;

    logic [1:0]  gnt, stb, cyc, we, rv, er, pe;
    logic [31:0] rd  [2];
    logic [31:0] adr [2];
    logic [3:0]  sel [2];

    always #5 clk = ~clk;

    ibex_instr_wb_bridge #(.MaxOutstanding(MaxOut), .RegResp(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_req(req), .instr_gnt(gnt[0]), .instr_addr(addr),
        .instr_rvalid(rv[0]), .instr_rdata(rd[0]), .instr_err(er[0]),
        .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_sel(sel[0]), .wb_adr(adr[0]),
        .wb_dat_i(dat), .wb_ack(ack), .wb_err(err), .wb_stall(stall), .proto_err(pe[0])
    );

    ibex_instr_wb_bridge #(.MaxOutstanding(MaxOut), .RegResp(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_req(req), .instr_gnt(gnt[1]), .instr_addr(addr),
        .instr_rvalid(rv[1]), .instr_rdata(rd[1]), .instr_err(er[1]),
        .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_sel(sel[1]), .wb_adr(adr[1]),
        .wb_dat_i(dat), .wb_ack(ack), .wb_err(err), .wb_stall(stall), .proto_err(pe[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endfunction

    // Memory contents the slave returns for a given address.
    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_F00D;
    endfunction

    // ---------------- slave environment ----------------
    typedef struct {
        logic [31:0] a;
        int          ready;
    } ent_t;

    ent_t        sq[$];
    int          cyc_n     = 0;
    bit          core_gnt  = 1'b0;
    int unsigned ack_dmin  = 0, ack_dmax = 0;
    int unsigned err_pct   = 0, stall_pct = 0, stray_pct = 0;
    bit          force_stall = 1'b0;
    bit          reset_ack   = 1'b0;
    logic [31:0] err_addr    = 32'h1;

    always @(negedge clk) begin : slave_track
        core_gnt = gnt[0];
        if (!rst_n) begin
            sq.delete();
        end else begin
            if ((ack || err) && sq.size() > 0) void'(sq.pop_front());
            if (stb[0] && !stall) sq.push_back('{addr, cyc_n + int'($urandom_range(ack_dmax, ack_dmin))});
        end
    end

    always @(posedge clk) begin : slave_drive
        cyc_n++;
        #1;
        ack   = 1'b0;
        err   = 1'b0;
        stall = 1'b0;
        dat   = $urandom;
        if (!rst_n) begin
            ack = reset_ack;
            dat = '0;
        end else begin
            stall = force_stall || ($urandom_range(99) < stall_pct);
            if (sq.size() > 0 && sq[0].ready <= cyc_n) begin
                dat = word_of(sq[0].a);
                if (sq[0].a == err_addr || $urandom_range(99) < err_pct) begin
                    err = 1'b1;
                    ack = 1'($urandom_range(1));
                end else begin
                    ack = 1'b1;
                end
            end else if (sq.size() == 0 && $urandom_range(99) < stray_pct) begin
                ack = 1'b1;
            end
        end
    end

    // ---------------- transaction-level model + compare ----------------
    logic [31:0] mq[$];          // granted, unanswered fetch addresses in order
    int          m_mode = 0;     // 0 normal, 1 draining after error, 2 one cycle with CYC low
    bit          m_proto = 1'b0;
    bit          m_rv1 = 1'b0, m_er1 = 1'b0;
    logic [31:0] m_rd1 = '0;
    bit          e_rsp, e_room, e_stb, e_gnt, e_cyc, e_err;
    logic [31:0] e_rd;

    always @(negedge clk) begin : compare
        if (!rst_n) begin
            mq.delete();
            m_mode  = 0;
            m_proto = 1'b0;
            m_rv1   = 1'b0;
            m_er1   = 1'b0;
            m_rd1   = '0;
            for (int i = 0; i < 2; i++) begin
                chk("rst_gnt", i, 32'(gnt[i]), 0);
                chk("rst_stb", i, 32'(stb[i]), 0);
                chk("rst_cyc", i, 32'(cyc[i]), 0);
                chk("rst_rvalid", i, 32'(rv[i]), 0);
                chk("rst_err", i, 32'(er[i]), 0);
                chk("rst_proto", i, 32'(pe[i]), 0);
            end
            chk("rst_rdata", 1, rd[1], 0);
        end else begin
            e_rsp  = (ack || err) && (mq.size() != 0);
            e_room = (mq.size() < MaxOut) || e_rsp;
            e_stb  = req && e_room && (m_mode == 0);
            e_gnt  = e_stb && !stall;
            e_cyc  = (m_mode != 2) && (e_stb || mq.size() != 0);
            e_err  = e_rsp && err;
            e_rd   = e_rsp ? word_of(mq[0]) : 32'h0;
            for (int i = 0; i < 2; i++) begin
                chk("gnt", i, 32'(gnt[i]), 32'(e_gnt));
                chk("stb", i, 32'(stb[i]), 32'(e_stb));
                chk("cyc", i, 32'(cyc[i]), 32'(e_cyc));
                chk("adr", i, adr[i], addr);
                chk("we", i, 32'(we[i]), 0);
                chk("sel", i, 32'(sel[i]), 32'hF);
                chk("proto", i, 32'(pe[i]), 32'(m_proto));
            end
            chk("rvalid", 0, 32'(rv[0]), 32'(e_rsp));
            chk("err", 0, 32'(er[0]), 32'(e_err));
            if (e_rsp) chk("rdata", 0, rd[0], e_rd);
            chk("rvalid", 1, 32'(rv[1]), 32'(m_rv1));
            chk("err", 1, 32'(er[1]), 32'(m_er1));
            chk("rdata", 1, rd[1], m_rd1);

            m_rv1 = e_rsp;
            m_er1 = e_err;
            if (e_rsp) m_rd1 = e_rd;
            if ((ack || err) && mq.size() == 0) m_proto = 1'b1;
            if (e_rsp) void'(mq.pop_front());
            if (e_gnt) mq.push_back(addr);
            if (m_mode == 2)                        m_mode = 0;
            else if (m_mode == 1 && mq.size() == 0) m_mode = 2;
            else if (m_mode == 0 && e_rsp && err)   m_mode = 1;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k = 0;
        req = 1'b0;
        while (sq.size() != 0 && k < 60) begin
            step();
            k++;
        end
        if (k == 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: %0d reads still outstanding after 60 cycles", sq.size());
        end
        step();
        step();
    endtask

    int n_cyc, n_rv0, n_rv1;

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        addr      = '0;
        reset_ack = 1'b1;

        // Reset with an ack on the bus: nothing leaks out.
        step();
        step();
        @(negedge clk);
        chk("t1_rvalid", 0, 32'(rv[0]), 0);
        chk("t1_rvalid", 1, 32'(rv[1]), 0);
        chk("t1_proto", 0, 32'(pe[0]), 0);
        chk("t1_cyc", 0, 32'(cyc[0]), 0);
        chk("t1_rdata", 1, rd[1], 0);
        reset_ack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("t1_idle_cyc", 0, 32'(cyc[0]), 0);
        chk("t1_idle_proto", 1, 32'(pe[1]), 0);

        // Back-to-back, zero-wait slave.
        n_cyc = 0; n_rv0 = 0; n_rv1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            req  = (i < 8);
            addr = (i < 8) ? 32'h80 + 32'(4 * i) : 32'h0;
            @(negedge clk);
            if (i < 8) chk("t2_gnt", 0, 32'(gnt[0]), 1);
            if (i == 9) chk("t2_cyc_drop", 0, 32'(cyc[0]), 0);
            n_cyc += int'(cyc[0]);
            n_rv0 += int'(rv[0]);
            n_rv1 += int'(rv[1]);
        end
        chk("t2_cyc_cycles", 0, 32'(n_cyc), 9);
        chk("t2_rvalid_cnt", 0, 32'(n_rv0), 8);
        chk("t2_rvalid_cnt", 1, 32'(n_rv1), 8);
        wait_idle();

        // Stall held for three cycles.
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            req  = 1'b1;
            addr = 32'h100;
            @(negedge clk);
            chk("t3_gnt", 0, 32'(gnt[0]), 0);
            chk("t3_stb", 0, 32'(stb[0]), 1);
            chk("t3_adr", 0, adr[0], 32'h100);
        end
        force_stall = 1'b0;
        step();
        @(negedge clk);
        chk("t3_gnt_after", 0, 32'(gnt[0]), 1);
        wait_idle();

        // Outstanding limit with slow acks.
        ack_dmin = 5;
        ack_dmax = 5;
        addr = 32'h200;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i > 0 && core_gnt) addr = addr + 32'h4;
            req = 1'b1;
            @(negedge clk);
            if (i < 6) chk("t4_gnt", 0, 32'(gnt[0]), (i < 2 || i == 5) ? 32'h1 : 32'h0);
            if (i == 5) chk("t4_rvalid", 0, 32'(rv[0]), 1);
            if (i == 6) chk("t4_cnt_full", 0, 32'(dut0.cnt), 2);
        end
        wait_idle();

        // Error on the first of two in flight.
        ack_dmin = 3;
        ack_dmax = 3;
        err_addr = 32'h300;
        for (int i = 0; i < 7; i++) begin
            step();
            req  = (i < 2) || (i >= 4);
            addr = (i == 0) ? 32'h300 : (i == 1) ? 32'h304 : 32'h400;
            @(negedge clk);
            case (i)
                1: chk("t5_gnt2", 0, 32'(gnt[0]), 1);
                3: begin
                    chk("t5_rvalid", 0, 32'(rv[0]), 1);
                    chk("t5_err", 0, 32'(er[0]), 1);
                end
                4: begin
                    chk("t5_drain_gnt", 0, 32'(gnt[0]), 0);
                    chk("t5_drain_stb", 0, 32'(stb[0]), 0);
                    chk("t5_rvalid2", 0, 32'(rv[0]), 1);
                    chk("t5_err2", 0, 32'(er[0]), 0);
                    chk("t5_err_reg", 1, 32'(er[1]), 1);
                end
                5: begin
                    chk("t5_gap_cyc", 0, 32'(cyc[0]), 0);
                    chk("t5_gap_gnt", 0, 32'(gnt[0]), 0);
                    chk("t5_rvalid2_reg", 1, 32'(rv[1]), 1);
                end
                6: chk("t5_regnt", 0, 32'(gnt[0]), 1);
                default: ;
            endcase
        end
        err_addr = 32'h1;
        ack_dmin = 0;
        ack_dmax = 0;
        wait_idle();

        // Stray ack with nothing outstanding.
        stray_pct = 100;
        step();
        @(negedge clk);
        chk("t6_stray_rvalid", 0, 32'(rv[0]), 0);
        stray_pct = 0;
        step();
        @(negedge clk);
        chk("t6_proto", 0, 32'(pe[0]), 1);
        chk("t6_proto", 1, 32'(pe[1]), 1);
        chk("t6_stray_rvalid", 1, 32'(rv[1]), 0);
        step();
        step();
        step();
        @(negedge clk);
        chk("t6_proto_sticky", 0, 32'(pe[0]), 1);

        // Random traffic with a reset dropped into the middle of it.
        ack_dmax  = 4;
        err_pct   = 8;
        stall_pct = 25;
        stray_pct = 2;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (c == 300 || c == 301) begin
                rst_n = 1'b0;
                req   = 1'b0;
            end else begin
                rst_n = 1'b1;
                if (!req || core_gnt) begin
                    req  = ($urandom_range(99) < 70);
                    addr = $urandom & 32'hFFFF_FFFC;
                end
            end
        end
        stray_pct = 0;
        err_pct   = 0;
        stall_pct = 0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
